// File: rtl/i2c_slave_fsm.sv
// I2C target (slave) controller with open-drain SDA and no clock stretching.
// Answers the 7-bit address OWN_ADDR. It passes received bytes to the MCU side
// and sends bytes that the MCU side supplies.
//
// Ports:
//   i2c_core_clk_i  core clock, at least 10x the SCL frequency
//   reset_i         asynchronous, active-high reset
//   enable_i        0 forces IDLE and releases SDA
//   i2c_scl_i       raw SCL line
//   i2c_sda_i       raw SDA line
//   i2c_sda_en_o    1 pulls SDA low, 0 releases it
//   rx_data_o       last byte received
//   rx_valid_o      1-cycle pulse when rx_data_o is updated
//   tx_data_i       next byte to send
//   tx_valid_i      tx_data_i holds a valid byte
//   tx_ready_o      1-cycle pulse; tx_data_i is consumed this cycle
//   addressed_o     high from the address ACK until STOP, START or a NACK
//   rw_o            R/W bit of the current transaction (1 = master reads)
//   stop_o          1-cycle pulse on STOP ending a transfer this target joined
//   nack_o          1-cycle pulse when the master NACKs a read byte
//   underrun_o      1-cycle pulse when a tx byte is needed but tx_valid_i = 0
module i2c_slave_fsm #(
    parameter logic [6:0]  OWN_ADDR  = 7'h50,
    parameter int unsigned DATA_SIZE = 8
) (
    input  logic                 i2c_core_clk_i,
    input  logic                 reset_i,
    input  logic                 enable_i,
    input  logic                 i2c_scl_i,
    input  logic                 i2c_sda_i,
    output logic                 i2c_sda_en_o,
    output logic [DATA_SIZE-1:0] rx_data_o,
    output logic                 rx_valid_o,
    input  logic [DATA_SIZE-1:0] tx_data_i,
    input  logic                 tx_valid_i,
    output logic                 tx_ready_o,
    output logic                 addressed_o,
    output logic                 rw_o,
    output logic                 stop_o,
    output logic                 nack_o,
    output logic                 underrun_o
);

    typedef enum logic [2:0] {
        StIdle, StAddr, StAddrAck, StRxData, StRxAck, StTxData, StTxAck, StWaitStop
    } state_e;

    // Line synchronisers plus one delay stage for edge detection.
    logic [1:0] scl_sync_q, sda_sync_q;
    logic       scl_dly_q, sda_dly_q;
    // Registered events. This extra stage gives 4 clocks from a raw SCL fall to an SDA change.
    logic       scl_rise_q, scl_fall_q, start_q, stop_q, sda_smp_q;

    always_ff @(posedge i2c_core_clk_i or posedge reset_i) begin
        if (reset_i) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
            scl_dly_q  <= 1'b1;
            sda_dly_q  <= 1'b1;
            scl_rise_q <= 1'b0;
            scl_fall_q <= 1'b0;
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
            sda_smp_q  <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[0], i2c_scl_i};
            sda_sync_q <= {sda_sync_q[0], i2c_sda_i};
            scl_dly_q  <= scl_sync_q[1];
            sda_dly_q  <= sda_sync_q[1];
            scl_rise_q <= scl_sync_q[1] & ~scl_dly_q;
            scl_fall_q <= ~scl_sync_q[1] & scl_dly_q;
            start_q    <= scl_sync_q[1] & scl_dly_q & ~sda_sync_q[1] & sda_dly_q;
            stop_q     <= scl_sync_q[1] & scl_dly_q & sda_sync_q[1] & ~sda_dly_q;
            sda_smp_q  <= sda_sync_q[1];
        end
    end

    state_e               state_q, state_d;
    logic [2:0]           bit_cnt_q, bit_cnt_d;   // counts bits sent or received in this byte
    logic                 byte_full_q, byte_full_d;
    logic [DATA_SIZE-1:0] shift_q, shift_d;
    logic [DATA_SIZE-1:0] tx_shift_q, tx_shift_d;
    logic [DATA_SIZE-1:0] rx_data_q, rx_data_d;
    logic                 sda_en_q, sda_en_d;
    logic                 rw_q, rw_d;
    logic                 addressed_q, addressed_d;
    // Stays set after a NACK, so the closing STOP of our transfer is still reported.
    logic                 session_q, session_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 stop_pls_q, stop_pls_d;
    logic                 nack_q, nack_d;
    logic                 underrun_q, underrun_d;
    logic                 tx_load;
    logic [DATA_SIZE-1:0] tx_byte;

    // An empty tx side sends all ones. To the master that reads as a released bus.
    assign tx_byte = tx_valid_i ? tx_data_i : '1;

    always_ff @(posedge i2c_core_clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= StIdle;
            bit_cnt_q   <= '0;
            byte_full_q <= 1'b0;
            shift_q     <= '0;
            tx_shift_q  <= '0;
            rx_data_q   <= '0;
            sda_en_q    <= 1'b0;
            rw_q        <= 1'b0;
            addressed_q <= 1'b0;
            session_q   <= 1'b0;
            rx_valid_q  <= 1'b0;
            stop_pls_q  <= 1'b0;
            nack_q      <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            byte_full_q <= byte_full_d;
            shift_q     <= shift_d;
            tx_shift_q  <= tx_shift_d;
            rx_data_q   <= rx_data_d;
            sda_en_q    <= sda_en_d;
            rw_q        <= rw_d;
            addressed_q <= addressed_d;
            session_q   <= session_d;
            rx_valid_q  <= rx_valid_d;
            stop_pls_q  <= stop_pls_d;
            nack_q      <= nack_d;
            underrun_q  <= underrun_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        byte_full_d = byte_full_q;
        shift_d     = shift_q;
        tx_shift_d  = tx_shift_q;
        rx_data_d   = rx_data_q;
        sda_en_d    = sda_en_q;
        rw_d        = rw_q;
        addressed_d = addressed_q;
        session_d   = session_q;
        rx_valid_d  = 1'b0;
        stop_pls_d  = 1'b0;
        nack_d      = 1'b0;
        underrun_d  = 1'b0;
        tx_load     = 1'b0;

        if (!enable_i) begin
            state_d     = StIdle;
            sda_en_d    = 1'b0;
            addressed_d = 1'b0;
            session_d   = 1'b0;
            bit_cnt_d   = '0;
            byte_full_d = 1'b0;
        end else if (start_q) begin
            // START and repeated START: any partial byte is dropped.
            state_d     = StAddr;
            sda_en_d    = 1'b0;
            addressed_d = 1'b0;
            session_d   = 1'b0;
            bit_cnt_d   = '0;
            byte_full_d = 1'b0;
        end else if (stop_q) begin
            state_d     = StIdle;
            sda_en_d    = 1'b0;
            stop_pls_d  = session_q;
            addressed_d = 1'b0;
            session_d   = 1'b0;
            bit_cnt_d   = '0;
            byte_full_d = 1'b0;
        end else begin
            case (state_q)
                StAddr, StRxData: begin
                    if (scl_rise_q) begin
                        shift_d = {shift_q[DATA_SIZE-2:0], sda_smp_q};
                        if (bit_cnt_q == 3'd7) begin
                            bit_cnt_d   = '0;
                            byte_full_d = 1'b1;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 3'd1;
                        end
                    end else if (scl_fall_q && byte_full_q) begin
                        byte_full_d = 1'b0;
                        if (state_q == StRxData) begin
                            rx_data_d  = shift_q;
                            rx_valid_d = 1'b1;
                            sda_en_d   = 1'b1;
                            state_d    = StRxAck;
                        end else if (shift_q[7:1] == OWN_ADDR) begin
                            sda_en_d    = 1'b1;
                            rw_d        = shift_q[0];
                            addressed_d = 1'b1;
                            session_d   = 1'b1;
                            state_d     = StAddrAck;
                        end else begin
                            state_d = StWaitStop;
                        end
                    end
                end
                StAddrAck: begin
                    if (scl_fall_q) begin
                        if (rw_q) begin
                            tx_load = 1'b1;
                        end else begin
                            sda_en_d = 1'b0;
                            state_d  = StRxData;
                        end
                    end
                end
                StRxAck: begin
                    if (scl_fall_q) begin
                        sda_en_d = 1'b0;
                        state_d  = StRxData;
                    end
                end
                StTxData: begin
                    if (scl_fall_q) begin
                        if (bit_cnt_q == 3'd7) begin
                            // The fall after bit 0 hands SDA to the master for its ACK.
                            sda_en_d  = 1'b0;
                            bit_cnt_d = '0;
                            state_d   = StTxAck;
                        end else begin
                            tx_shift_d = tx_shift_q << 1;
                            sda_en_d   = ~tx_shift_q[DATA_SIZE-2];
                            bit_cnt_d  = bit_cnt_q + 3'd1;
                        end
                    end
                end
                StTxAck: begin
                    if (scl_rise_q && sda_smp_q) begin
                        nack_d      = 1'b1;
                        addressed_d = 1'b0;
                        state_d     = StWaitStop;
                    end else if (scl_fall_q) begin
                        tx_load = 1'b1;
                    end
                end
                default: ;
            endcase

            if (tx_load) begin
                tx_shift_d = tx_byte;
                sda_en_d   = ~tx_byte[DATA_SIZE-1];
                bit_cnt_d  = '0;
                underrun_d = ~tx_valid_i;
                state_d    = StTxData;
            end
        end
    end

    always_comb begin
        i2c_sda_en_o = sda_en_q;
        rx_data_o    = rx_data_q;
        rx_valid_o   = rx_valid_q;
        tx_ready_o   = tx_load & tx_valid_i;
        addressed_o  = addressed_q;
        rw_o         = rw_q;
        stop_o       = stop_pls_q;
        nack_o       = nack_q;
        underrun_o   = underrun_q;
    end

endmodule

// File: tb/tb_i2c_slave_fsm.sv
// Directed bench for i2c_slave_fsm. It has a bit-banged I2C master and a
// wired-AND SDA line. Monitors count the output pulses.
module tb_i2c_slave_fsm;

    localparam int Q = 5;  // core clocks per quarter SCL period

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b1;
    logic       m_scl = 1'b1;
    logic       m_sda = 1'b1;
    logic       sda_en;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, addressed, rw, stop_p, nack_p, underrun;
    logic       sda_line;

    assign sda_line = m_sda & ~sda_en;

    always #5 clk = ~clk;

    i2c_slave_fsm #(.OWN_ADDR(7'h50), .DATA_SIZE(8)) dut (
        .i2c_core_clk_i (clk),
        .reset_i        (reset),
        .enable_i       (enable),
        .i2c_scl_i      (m_scl),
        .i2c_sda_i      (sda_line),
        .i2c_sda_en_o   (sda_en),
        .rx_data_o      (rx_data),
        .rx_valid_o     (rx_valid),
        .tx_data_i      (tx_data),
        .tx_valid_i     (tx_valid),
        .tx_ready_o     (tx_ready),
        .addressed_o    (addressed),
        .rw_o           (rw),
        .stop_o         (stop_p),
        .nack_o         (nack_p),
        .underrun_o     (underrun)
    );

    int         n_vec = 0;
    int         n_err = 0;
    int         rx_cnt = 0, txr_cnt = 0, nack_cnt = 0, stop_cnt = 0, unr_cnt = 0;
    int         en_cyc = 0, adr_cyc = 0;
    logic [7:0] rx_log[$];
    int         b_rx, b_txr, b_nack, b_stop, b_unr, b_en, b_adr;

    always @(negedge clk) begin
        if (rx_valid) begin
            rx_cnt <= rx_cnt + 1;
            rx_log.push_back(rx_data);
        end
        if (tx_ready)  txr_cnt  <= txr_cnt + 1;
        if (nack_p)    nack_cnt <= nack_cnt + 1;
        if (stop_p)    stop_cnt <= stop_cnt + 1;
        if (underrun)  unr_cnt  <= unr_cnt + 1;
        if (sda_en)    en_cyc   <= en_cyc + 1;
        if (addressed) adr_cyc  <= adr_cyc + 1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running, expected to finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic snap();
        b_rx = rx_cnt; b_txr = txr_cnt; b_nack = nack_cnt; b_stop = stop_cnt;
        b_unr = unr_cnt; b_en = en_cyc; b_adr = adr_cyc;
    endtask

    function automatic logic [31:0] rx_at(input int idx);
        return (rx_log.size() > idx) ? {24'h0, rx_log[idx]} : 32'hDEAD;
    endfunction

    task automatic wq();
        repeat (Q) @(negedge clk);
    endtask

    // Works from an idle bus and as a repeated START with SCL low.
    task automatic start_cond();
        m_sda = 1'b1; wq();
        m_scl = 1'b1; wq();
        m_sda = 1'b0; wq();
        m_scl = 1'b0; wq();
    endtask

    task automatic stop_cond();
        m_sda = 1'b0; wq();
        m_scl = 1'b1; wq();
        m_sda = 1'b1; wq();
        wq();
    endtask

    task automatic clock_bit(input logic b, output logic line, output logic en);
        m_sda = b;    wq();
        m_scl = 1'b1; wq();
        line = sda_line;
        en   = sda_en;
        wq();
        m_scl = 1'b0; wq();
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic l, e;
        for (int i = 7; i >= 0; i--) clock_bit(b[i], l, e);
        clock_bit(1'b1, ack, e);
    endtask

    task automatic read_byte(input logic mack, output logic [7:0] d, output logic line_ack,
                             output logic en_ack);
        logic l, e;
        for (int i = 7; i >= 0; i--) begin
            clock_bit(1'b1, l, e);
            d[i] = l;
        end
        clock_bit(mack, line_ack, en_ack);
    endtask

    logic       ack, l, e;
    logic [7:0] d;
    int         base;

    initial begin
        repeat (3) @(negedge clk);
        check("reset_outputs",
              {sda_en, rx_data, rx_valid, tx_ready, addressed, rw, stop_p, nack_p, underrun},
              '0);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        // 1: write 0xA0, 0xA5, 0x3C, STOP
        snap(); base = rx_log.size();
        start_cond();
        write_byte(8'hA0, ack); check("t1_addr_ack", ack, 1'b0);
        check("t1_addressed", addressed, 1'b1);
        check("t1_rw", rw, 1'b0);
        write_byte(8'hA5, ack); check("t1_d0_ack", ack, 1'b0);
        write_byte(8'h3C, ack); check("t1_d1_ack", ack, 1'b0);
        stop_cond();
        check("t1_rx_cnt", rx_cnt - b_rx, 2);
        check("t1_rx0", rx_at(base), 8'hA5);
        check("t1_rx1", rx_at(base + 1), 8'h3C);
        check("t1_stop_cnt", stop_cnt - b_stop, 1);
        check("t1_addressed_after_stop", addressed, 1'b0);

        // 2: write to 0x51, nobody answers
        snap();
        start_cond();
        write_byte(8'hA2, ack); check("t2_addr_nack", ack, 1'b1);
        write_byte(8'h55, ack); check("t2_data_nack", ack, 1'b1);
        stop_cond();
        check("t2_sda_never_low", en_cyc - b_en, 0);
        check("t2_rx_cnt", rx_cnt - b_rx, 0);
        check("t2_addressed_cyc", adr_cyc - b_adr, 0);
        check("t2_stop_cnt", stop_cnt - b_stop, 0);

        // 3: read 0x96 (ACK) then 0x5A (NACK)
        snap();
        tx_valid = 1'b1; tx_data = 8'h96;
        start_cond();
        write_byte(8'hA1, ack); check("t3_addr_ack", ack, 1'b0);
        check("t3_rw", rw, 1'b1);
        tx_data = 8'h5A;  // first byte was taken at the address ACK fall
        read_byte(1'b0, d, l, e);
        check("t3_byte0", d, 8'h96);
        check("t3_ack_slot_released", e, 1'b0);
        read_byte(1'b1, d, l, e);
        check("t3_byte1", d, 8'h5A);
        check("t3_nack_slot_line", l, 1'b1);
        stop_cond();
        check("t3_tx_ready_cnt", txr_cnt - b_txr, 2);
        check("t3_nack_cnt", nack_cnt - b_nack, 1);
        check("t3_underrun_cnt", unr_cnt - b_unr, 0);

        // 4: read with nothing to send
        snap();
        tx_valid = 1'b0; tx_data = 8'h00;
        start_cond();
        write_byte(8'hA1, ack); check("t4_addr_ack", ack, 1'b0);
        read_byte(1'b1, d, l, e);
        stop_cond();
        check("t4_byte", d, 8'hFF);
        check("t4_underrun_cnt", unr_cnt - b_unr, 1);
        check("t4_tx_ready_cnt", txr_cnt - b_txr, 0);

        // 5: write 0x11, repeated START, read one byte, NACK, STOP
        snap(); base = rx_log.size();
        start_cond();
        write_byte(8'hA0, ack); check("t5_w_addr_ack", ack, 1'b0);
        check("t5_rw_w", rw, 1'b0);
        write_byte(8'h11, ack); check("t5_data_ack", ack, 1'b0);
        tx_valid = 1'b1; tx_data = 8'hC3;
        start_cond();
        write_byte(8'hA1, ack); check("t5_r_addr_ack", ack, 1'b0);
        check("t5_rw_r", rw, 1'b1);
        read_byte(1'b1, d, l, e);
        check("t5_rd_byte", d, 8'hC3);
        stop_cond();
        tx_valid = 1'b0;
        check("t5_rx_cnt", rx_cnt - b_rx, 1);
        check("t5_rx0", rx_at(base), 8'h11);
        check("t5_nack_cnt", nack_cnt - b_nack, 1);
        check("t5_stop_cnt", stop_cnt - b_stop, 1);

        // 6: reset while the ACK is driven low
        start_cond();
        write_byte(8'hA0, ack); check("t6_addr_ack", ack, 1'b0);
        for (int i = 7; i >= 0; i--) clock_bit(d[i], l, e);
        m_sda = 1'b1;
        check("t6_ack_driven", sda_en, 1'b1);
        #3 reset = 1'b1;
        #1 check("t6_async_release", sda_en, 1'b0);
        check("t6_outputs_zero", {rx_data, rx_valid, addressed, rw, stop_p, nack_p, underrun}, '0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        wq(); m_scl = 1'b1; wq(); wq(); m_scl = 1'b0; wq();
        snap();
        write_byte(8'hA0, ack); check("t6_no_start_nack", ack, 1'b1);
        check("t6_sda_never_low", en_cyc - b_en, 0);
        check("t6_rx_cnt", rx_cnt - b_rx, 0);
        stop_cond();

        // 7: disabled target ignores its own address
        snap();
        enable = 1'b0;
        start_cond();
        write_byte(8'hA0, ack); check("t7_disabled_nack", ack, 1'b1);
        stop_cond();
        check("t7_sda_never_low", en_cyc - b_en, 0);
        enable = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
